// File: rtl/enc_input_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg: shared constants for the rotary-encoder input conditioner.
//   ENC_STABLE_CYCLES_DEF : default debounce stability window (100 us @ 12 MHz)
//   ENC_LONG_PRESS_DEF    : default long-press hold time (1 s @ 12 MHz)
//   ENC_HOLD_W            : width of the long-press hold counter
//   ENC_CH_IDLE/SW_IDLE   : raw pin idle levels, used as reset values
//   enc_cnt_w(n)          : width of a debounce counter for window n
// ---------------------------------------------------------------------------
package enc_pkg;

    localparam int   ENC_STABLE_CYCLES_DEF = 1200;
    localparam int   ENC_LONG_PRESS_DEF    = 12000000;
    localparam int   ENC_HOLD_W            = 24;
    localparam logic ENC_CH_IDLE           = 1'b1;
    localparam logic ENC_SW_IDLE           = 1'b1;

    function automatic int enc_cnt_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/enc_input_conditioner_debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit: two-flop synchroniser followed by a stability counter.
// The clean output only moves after the synchronised input has disagreed
// with it for STABLE_CYCLES consecutive cycles; any agreement restarts the
// count.
//   clk  : system clock
//   rst  : synchronous reset, active high
//   din  : raw asynchronous input
//   dout : debounced level (resets to RESET_VAL)
// ---------------------------------------------------------------------------
module debounce_bit
    import enc_pkg::*;
#(
    parameter int   STABLE_CYCLES = ENC_STABLE_CYCLES_DEF,
    parameter logic RESET_VAL     = ENC_CH_IDLE
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int               CNT_W   = enc_cnt_w(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             clean_q, clean_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d    = din;
        s2_d    = s1_q;
        clean_d = clean_q;
        cnt_d   = cnt_q;
        if (s2_q == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // window complete: accept the new level and restart
            clean_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= RESET_VAL;
            s2_q    <= RESET_VAL;
            clean_q <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = clean_q;

endmodule

// File: rtl/enc_input_conditioner.sv
// ---------------------------------------------------------------------------
// enc_input_conditioner: synchronises and debounces the rotary encoder pins
// and derives switch press/release pulses for the quadrature decoder.
//   clk, rst          : system clock, synchronous active-high reset
//   enc_ch_a/b        : raw encoder channels (idle high)
//   enc_sw            : raw push switch (active low)
//   ch_a_clean/b_clean: debounced channel levels
//   sw_pressed        : debounced switch, active high
//   sw_press_pulse    : one cycle on the first cycle sw_pressed reads 1
//   sw_release_pulse  : one cycle on the first cycle sw_pressed reads 0
//   long_press_pulse  : one cycle after LONG_PRESS_CYCLES of continuous press
// Build option: define ENC_LONG_PRESS_EN to build the long-press hold
// counter; otherwise long_press_pulse is tied low.
// ---------------------------------------------------------------------------
module enc_input_conditioner
    import enc_pkg::*;
#(
    parameter int STABLE_CYCLES     = ENC_STABLE_CYCLES_DEF,
    parameter int LONG_PRESS_CYCLES = ENC_LONG_PRESS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enc_ch_a,
    input  logic enc_ch_b,
    input  logic enc_sw,
    output logic ch_a_clean,
    output logic ch_b_clean,
    output logic sw_pressed,
    output logic sw_press_pulse,
    output logic sw_release_pulse,
    output logic long_press_pulse
);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535) begin : g_bad_stable
        $error("STABLE_CYCLES out of range 2..65535");
    end
    if (LONG_PRESS_CYCLES < 1 || LONG_PRESS_CYCLES > (1 << ENC_HOLD_W)) begin : g_bad_long
        $error("LONG_PRESS_CYCLES does not fit the hold counter");
    end

    logic sw_clean;

    debounce_bit #(.STABLE_CYCLES(STABLE_CYCLES), .RESET_VAL(ENC_CH_IDLE)) u_db_a (
        .clk(clk), .rst(rst), .din(enc_ch_a), .dout(ch_a_clean)
    );
    debounce_bit #(.STABLE_CYCLES(STABLE_CYCLES), .RESET_VAL(ENC_CH_IDLE)) u_db_b (
        .clk(clk), .rst(rst), .din(enc_ch_b), .dout(ch_b_clean)
    );
    debounce_bit #(.STABLE_CYCLES(STABLE_CYCLES), .RESET_VAL(ENC_SW_IDLE)) u_db_sw (
        .clk(clk), .rst(rst), .din(enc_sw), .dout(sw_clean)
    );

    assign sw_pressed = ~sw_clean;

    // Previous-cycle copy of sw_pressed; pulses come straight from flops so
    // they line up with the cycle the debounced level changes.
    logic sw_prev_q, sw_prev_d;

    always_comb sw_prev_d = sw_pressed;

    always_ff @(posedge clk) begin
        if (rst) sw_prev_q <= 1'b0;
        else     sw_prev_q <= sw_prev_d;
    end

    assign sw_press_pulse   =  sw_pressed & ~sw_prev_q;
    assign sw_release_pulse = ~sw_pressed &  sw_prev_q;

`ifdef ENC_LONG_PRESS_EN
    localparam logic [ENC_HOLD_W-1:0] HOLD_MAX = ENC_HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic [ENC_HOLD_W-1:0] hold_q, hold_d;
    logic                  fired_q, fired_d;
    logic                  long_q, long_d;

    // The counter parks at HOLD_MAX; fired_q keeps it to one pulse per press.
    always_comb begin
        hold_d  = hold_q;
        fired_d = fired_q;
        long_d  = 1'b0;
        if (!sw_pressed) begin
            hold_d  = '0;
            fired_d = 1'b0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
        end else if (!fired_q) begin
            long_d  = 1'b1;
            fired_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    assign long_press_pulse = long_q;
`else
    assign long_press_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_enc_input_conditioner.sv
// ---------------------------------------------------------------------------
// Bench for enc_input_conditioner with STABLE_CYCLES=4, LONG_PRESS_CYCLES=10.
// The reference model keeps a sliding window of the pin samples seen at each
// clock edge: a clean level flips when every synchronised sample in the last
// STABLE_CYCLES cycles disagrees with it. Expected outputs are queued per
// cycle and a monitor compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_enc_input_conditioner;

    localparam int S = 4;
    localparam int L = 10;

    logic clk = 1'b0;
    logic rst, enc_ch_a, enc_ch_b, enc_sw;
    logic ch_a_clean, ch_b_clean, sw_pressed;
    logic sw_press_pulse, sw_release_pulse, long_press_pulse;

    always #5 clk = ~clk;

    enc_input_conditioner #(.STABLE_CYCLES(S), .LONG_PRESS_CYCLES(L)) dut (
        .clk(clk), .rst(rst),
        .enc_ch_a(enc_ch_a), .enc_ch_b(enc_ch_b), .enc_sw(enc_sw),
        .ch_a_clean(ch_a_clean), .ch_b_clean(ch_b_clean),
        .sw_pressed(sw_pressed), .sw_press_pulse(sw_press_pulse),
        .sw_release_pulse(sw_release_pulse), .long_press_pulse(long_press_pulse)
    );

    typedef struct packed {
        logic a, b, p, pp, rp, lp;
    } exp_t;

    exp_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;
    string phase = "reset";

    // model state: pin history per channel (index 0 = newest edge sample)
    bit hist [3][S+2];
    bit mclean[3];
    bit prev_pressed;
    int run;

    initial begin
        for (int c = 0; c < 3; c++) begin
            mclean[c] = 1'b1;
            for (int j = 0; j < S + 2; j++) hist[c][j] = 1'b1;
        end
        prev_pressed = 1'b0;
        run = 0;
    end

    // Drive pins for the next rising edge, predict the outputs after it.
    task automatic drive(input bit r, input bit va, input bit vb, input bit vs);
        bit   pins[3];
        bit   flip;
        bit   pressed;
        exp_t e;
        rst = r; enc_ch_a = va; enc_ch_b = vb; enc_sw = vs;
        pins[0] = va; pins[1] = vb; pins[2] = vs;
        for (int c = 0; c < 3; c++) begin
            for (int j = S + 1; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = pins[c];
            if (r) begin
                // reset forces both sync stages and the clean level idle
                hist[c][0] = 1'b1;
                hist[c][1] = 1'b1;
                mclean[c]  = 1'b1;
            end else begin
                flip = 1'b1;
                for (int j = 2; j < S + 2; j++)
                    if (hist[c][j] == mclean[c]) flip = 1'b0;
                if (flip) mclean[c] = ~mclean[c];
            end
        end
        pressed = ~mclean[2];
        e.a  = mclean[0];
        e.b  = mclean[1];
        e.p  = pressed;
        e.pp = !r && pressed && !prev_pressed;
        e.rp = !r && !pressed && prev_pressed;
`ifdef ENC_LONG_PRESS_EN
        e.lp = !r && (run == L);
`else
        e.lp = 1'b0;
`endif
        run          = (r || !pressed) ? 0 : run + 1;
        prev_pressed = r ? 1'b0 : pressed;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n, input bit va, input bit vb, input bit vs);
        for (int i = 0; i < n; i++) drive(1'b0, va, vb, vs);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e, act;
            e   = exp_q.pop_front();
            act = '{ch_a_clean, ch_b_clean, sw_pressed,
                    sw_press_pulse, sw_release_pulse, long_press_pulse};
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s @%0t: got a/b/pr/pp/rp/lp=%b want %b",
                         phase, $time, act, e);
            end
        end
    end

    initial begin
        bit ra, rb, rs;
        // reset with non-idle pins: outputs must show reset levels
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        hold(10, 1, 1, 1);

        phase = "a_step";
        hold(12, 0, 1, 1);
        hold(10, 1, 1, 1);

        phase = "glitch3";
        hold(3, 0, 1, 1);
        hold(10, 1, 1, 1);
        phase = "glitch4";
        hold(4, 0, 1, 1);
        hold(12, 1, 1, 1);

        phase = "quadrature";
        hold(8, 1, 1, 1);
        hold(8, 0, 1, 1);
        hold(8, 0, 0, 1);
        hold(8, 1, 0, 1);
        hold(12, 1, 1, 1);

        phase = "switch";
        hold(20, 1, 1, 0);
        hold(15, 1, 1, 1);

        phase = "reset_mid";
        hold(4, 0, 1, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        hold(3, 1, 1, 1);
        hold(8, 0, 1, 1);
        hold(10, 1, 1, 1);

        phase = "random";
        ra = 1; rb = 1; rs = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0)  ra = ~ra;
            if ($urandom_range(0, 4) == 0)  rb = ~rb;
            if ($urandom_range(0, 19) == 0) rs = ~rs;
            drive($urandom_range(0, 149) == 0, ra, rb, rs);
        end

        phase = "drain";
        hold(12, 1, 1, 1);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d queued, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enc_input_conditioner.md
Name: enc_input_conditioner

Overview:
Input-conditioning stage between the raw rotary-encoder pins and the quadrature decoder.
- Synchronises enc_ch_a, enc_ch_b and enc_sw into clk with two flops each.
- Debounces each channel with a per-bit stability counter.
- Presents glitch-free A/B levels to the decoder, plus an active-high switch level and single-cycle press/release pulses.
- The decoder consumes ch_a_clean and ch_b_clean directly in place of the raw pins.

Parameters:
STABLE_CYCLES, 1200, consecutive clk cycles a synchronised input must differ from its clean value before the clean value updates (100 us at 12 MHz); legal range 2..65535.
LONG_PRESS_CYCLES, 12000000, clk cycles sw_pressed must stay high before long_press_pulse fires (1 s at 12 MHz); used only with the optional feature.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  synchronous reset, active high.
enc_ch_a  input  1  raw encoder channel A, asynchronous, idle high.
enc_ch_b  input  1  raw encoder channel B, asynchronous, idle high.
enc_sw  input  1  raw push switch, asynchronous, active low.
ch_a_clean  output  1  debounced channel A level.
ch_b_clean  output  1  debounced channel B level.
sw_pressed  output  1  debounced switch level, active high (inverted enc_sw).
sw_press_pulse  output  1  one-cycle pulse on the cycle sw_pressed rises.
sw_release_pulse  output  1  one-cycle pulse on the cycle sw_pressed falls.
long_press_pulse  output  1  one-cycle long-press pulse; tied 0 when the feature is compiled out.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active high.
- Reset values:
  - sync flops: A=1, B=1, SW=1 (raw idle levels).
  - ch_a_clean=1, ch_b_clean=1, sw_pressed=0.
  - all pulses 0; all counters 0.
- Reset mid-operation: any debounce in progress is discarded; no pulse is emitted on the cycle rst is high or on the first cycle after it.
- Synchroniser: two flops per input. s2 is the synchronised value and lags the pin by 2 clk.
- Debounce, per bit. State is clean (1b) and cnt (width clog2(STABLE_CYCLES)):
  - If s2 == clean: cnt <= 0.
  - If s2 != clean and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - If s2 != clean and cnt == STABLE_CYCLES-1: clean <= s2, cnt <= 0.
- Latency: a clean step on a pin appears on the clean output exactly 2+STABLE_CYCLES rising edges later.
- Glitch rejection: any glitch shorter than STABLE_CYCLES synchronised cycles resets cnt and never reaches the output. A glitch of exactly STABLE_CYCLES cycles passes.
- Channel independence: the channels share no state. Simultaneous A and B transitions are each debounced independently and may update on the same cycle.
- Edge pulses:
  - Registered comparison of the next and current sw_pressed.
  - sw_press_pulse is high on the same cycle sw_pressed first reads 1; sw_release_pulse likewise on the falling edge.
  - The two pulses are never high together.
- Counter arithmetic never wraps; cnt saturates by the compare at STABLE_CYCLES-1.

Optional Feature:
Macro ENC_LONG_PRESS_EN.
- Defined:
  - A 24-bit hold counter clears while sw_pressed=0 and increments while sw_pressed=1.
  - When it reaches LONG_PRESS_CYCLES-1, long_press_pulse is high for exactly one cycle. The counter then holds at that value, so there is one pulse per press.
  - Release clears the counter.
  - sw_release_pulse is unaffected.
- Not defined: no hold counter is built and long_press_pulse is a constant 0.

Decomposition:
- Package enc_pkg holds:
  - defaults ENC_STABLE_CYCLES_DEF and ENC_LONG_PRESS_DEF;
  - reset levels ENC_CH_IDLE=1 and ENC_SW_IDLE=1;
  - the function enc_cnt_w(n) returning clog2(n).
- Sub-module debounce_bit (parameter STABLE_CYCLES, RESET_VAL; ports clk, rst, din, dout) contains the 2-flop sync and the stability counter. It is instantiated three times.
- Edge detection and the long-press counter live in the top.

Test Plan:
- All tests use STABLE_CYCLES=4 and LONG_PRESS_CYCLES=10.
- rst held 3 cycles with pins A=0 B=0 SW=0 -> outputs read A=1 B=1 pressed=0 and no pulses during or on the first cycle after reset.
- A steps 1->0 at edge 0 and holds -> ch_a_clean falls at edge 6, not earlier; ch_b_clean stays 1.
- A low glitch of 3 cycles -> ch_a_clean stays 1. A low glitch of exactly 4 synchronised cycles -> ch_a_clean goes 0 for 4 cycles.
- Quadrature sequence AB=11,01,00,10,11 with 8 cycles per state -> the clean outputs reproduce the sequence delayed by 6 cycles, with no extra transitions.
- SW held low 20 cycles then released -> sw_press_pulse fires once at the pressed rise and sw_release_pulse fires once at the fall; with ENC_LONG_PRESS_EN, long_press_pulse fires once, 10 cycles after the pressed rise.
- rst asserted while cnt=2 during an A transition -> after release cnt=0 and ch_a_clean=1; no pulse is emitted.
